// File: rtl/seg7_led_writer_pkg.sv
// Shared constants for the seven-segment/LED writer: MMIO addresses, the blank
// pattern and the active-low hex glyph table ({g,f,e,d,c,b,a}, 0 = segment on).
package seg7_led_writer_pkg;

  localparam logic [31:0] SEG7_ADDR_LED   = 32'hFFFF_FC60;
  localparam logic [31:0] SEG7_ADDR_DIGLO = 32'hFFFF_FC62;
  localparam logic [31:0] SEG7_ADDR_DIGHI = 32'hFFFF_FC64;
  localparam logic [31:0] SEG7_ADDR_CTRL  = 32'hFFFF_FC66;

  localparam logic [7:0] SEG7_BLANK = 8'hFF;

  // Element k is the glyph for hex digit k; F sits in the top slot.
  localparam logic [15:0][6:0] SEG7_GLYPH_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to 7-segment active-low decoder; zero latency, no
// flow control.
module seg7_hex_decode
  import seg7_led_writer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG7_GLYPH_TBL[nibble];

endmodule

// File: rtl/seg7_led_writer.sv
// MMIO LED + 8-digit seven-segment writer; register writes land on the store edge,
// display outputs are registered one cycle behind the scan state; SEG7_BLINK_EN adds digit blinking.
module seg7_led_writer
  import seg7_led_writer_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        outCtrl,
  input  logic        writeEnable,
  input  logic [31:0] address,
  input  logic [15:0] writeData,
  output logic [15:0] led,
  output logic [7:0]  segAnode,
  output logic [7:0]  segCathode
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [15:0]      led_q, led_d;
  logic [15:0]      dig_lo_q, dig_lo_d;
  logic [15:0]      dig_hi_q, dig_hi_d;
  logic [15:0]      ctrl_q, ctrl_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [7:0]       seg_anode_q, seg_anode_d;
  logic [7:0]       seg_cathode_q, seg_cathode_d;

  logic        wr_en;
  logic        scan_tick;
  logic        digit_on;
  logic [31:0] digits;
  logic [3:0]  sel_nibble;
  logic [6:0]  glyph;

`ifdef SEG7_BLINK_EN
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
`else
  logic unused_blink;
  assign unused_blink = (^ctrl_q[15:8]) ^ (BLINK_FRAMES > 0);
`endif

  assign digits     = {dig_hi_q, dig_lo_q};
  assign sel_nibble = digits[{digit_idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (sel_nibble),
    .seg_n  (glyph)
  );

  always_comb begin
    led_d       = led_q;
    dig_lo_d    = dig_lo_q;
    dig_hi_d    = dig_hi_q;
    ctrl_d      = ctrl_q;
    wr_en       = outCtrl && writeEnable;

    if (wr_en) begin
      case (address)
        SEG7_ADDR_LED:   led_d    = writeData;
        SEG7_ADDR_DIGLO: dig_lo_d = writeData;
        SEG7_ADDR_DIGHI: dig_hi_d = writeData;
        SEG7_ADDR_CTRL:  ctrl_d   = writeData;
        default:         ;
      endcase
    end

    scan_tick   = (div_cnt_q == DIV_MAX);
    div_cnt_d   = scan_tick ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d = scan_tick ? digit_idx_q + 3'd1 : digit_idx_q;

    // Outputs follow the current register/scan state, so anode and cathode move together.
    digit_on = ctrl_q[{1'b0, digit_idx_q}];

`ifdef SEG7_BLINK_EN
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (scan_tick && digit_idx_q == 3'd7) begin
      if (frame_cnt_q == FRM_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
    if (blink_phase_q && ctrl_q[{1'b1, digit_idx_q}]) begin
      digit_on = 1'b0;
    end
`endif

    seg_anode_d   = digit_on ? ~(8'b1 << digit_idx_q) : SEG7_BLANK;
    seg_cathode_d = digit_on ? {1'b1, glyph} : SEG7_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q         <= '0;
      dig_lo_q      <= '0;
      dig_hi_q      <= '0;
      ctrl_q        <= '0;
      div_cnt_q     <= '0;
      digit_idx_q   <= '0;
      seg_anode_q   <= SEG7_BLANK;
      seg_cathode_q <= SEG7_BLANK;
`ifdef SEG7_BLINK_EN
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      led_q         <= led_d;
      dig_lo_q      <= dig_lo_d;
      dig_hi_q      <= dig_hi_d;
      ctrl_q        <= ctrl_d;
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      seg_anode_q   <= seg_anode_d;
      seg_cathode_q <= seg_cathode_d;
`ifdef SEG7_BLINK_EN
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign led        = led_q;
  assign segAnode   = seg_anode_q;
  assign segCathode = seg_cathode_q;

endmodule
